// File: rtl/ext_access_pkg.sv
// ext_access_pkg: shared types and constants for the external access controller.
//   state_e          - controller FSM encoding (IDLE / WAIT / RESP)
//   ERR_RDATA        - read data returned to the CPU when an access times out
//   DEF_TIMEOUT_CYC  - default number of WAIT cycles before an access is aborted
package ext_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [31:0] ERR_RDATA       = 32'hDEAD_BEEF;
  localparam logic [15:0] DEF_TIMEOUT_CYC = 16'd1000;

endpackage

// File: rtl/ext_access_controller_if.sv
// ext_access_controller_if: CPU-side and target-side signals of the external
// access controller bundled into one interface.
//   CPU side    : daddr, dwdata, we_i, en_slave, en_master -> rdata_o, stall_o, err_o
//   target side : done_slave/done_master, slv_rdata/mst_rdata -> slv_req, mst_req,
//                 ext_addr, ext_wdata, ext_we
// Modports:
//   slave  - the controller's view (answers the CPU, drives the targets)
//   master - the environment's view (CPU plus the two target peripherals)
interface ext_access_controller_if;

  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  we_i;
  logic        en_slave;
  logic        en_master;
  logic        done_slave;
  logic        done_master;
  logic [31:0] slv_rdata;
  logic [31:0] mst_rdata;
  logic        slv_req;
  logic        mst_req;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic [3:0]  ext_we;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        err_o;

  modport slave (
    input  daddr, dwdata, we_i, en_slave, en_master,
    input  done_slave, done_master, slv_rdata, mst_rdata,
    output slv_req, mst_req, ext_addr, ext_wdata, ext_we,
    output rdata_o, stall_o, err_o
  );

  modport master (
    output daddr, dwdata, we_i, en_slave, en_master,
    output done_slave, done_master, slv_rdata, mst_rdata,
    input  slv_req, mst_req, ext_addr, ext_wdata, ext_we,
    input  rdata_o, stall_o, err_o
  );

endinterface

// File: rtl/ext_timeout_counter.sv
// ext_timeout_counter: 16-bit WAIT-cycle counter for access timeouts.
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - restart the count at zero (asserted on entry to WAIT)
//   en         - count this cycle (high while in WAIT)
//   expired    - high on the TIMEOUT_CYC-th counted cycle (TIMEOUT_CYC >= 1)
module ext_timeout_counter
  import ext_access_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [15:0] cnt;

  // cnt holds the number of completed WAIT cycles, so the N-th WAIT cycle
  // sees cnt == N-1; flagging there lets the FSM leave WAIT after exactly N.
  assign expired = (cnt == (TIMEOUT_CYC - 16'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (clr)            cnt <= '0;
    else if (en && !expired) cnt <= cnt + 16'd1;
  end

endmodule

// File: rtl/ext_access_controller.sv
// ext_access_controller: stalls the CPU while a decoded access is forwarded to
// one of two external targets (slave or master peripheral), then returns the
// target's read data in a single RESP cycle.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - ext_access_controller_if.slave (CPU request/response and
//                target req/done/rdata plus latched ext_addr/ext_wdata/ext_we)
// Optional feature: define EXT_ACCESS_TIMEOUT_EN to bound WAIT to TIMEOUT_CYC
// cycles; an expired access answers ERR_RDATA with a one-cycle err_o pulse.
module ext_access_controller
  import ext_access_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ext_access_controller_if.slave   bus
);

  state_e      state, state_nxt;
  logic        tgt_slv;            // latched target: 1 = slave, 0 = master
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  we_q;
  logic        accept;
  logic        sel_done;
  logic [31:0] sel_rdata;
  logic        timeout;

  assign accept = (state == ST_IDLE) && (bus.en_slave || bus.en_master);

  // Only the latched target's completion is looked at; the other one's
  // done/rdata are ignored for the whole access.
  assign sel_done  = tgt_slv ? bus.done_slave : bus.done_master;
  assign sel_rdata = tgt_slv ? bus.slv_rdata  : bus.mst_rdata;

`ifdef EXT_ACCESS_TIMEOUT_EN
  logic tmo_expired;
  logic err_q;

  ext_timeout_counter #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .en      (state == ST_WAIT),
    .expired (tmo_expired)
  );

  assign timeout = tmo_expired;

  // err_q is set only on the WAIT->RESP transition caused by a timeout, so it
  // is high for the RESP cycle alone; done on the same cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= (state == ST_WAIT) && !sel_done && tmo_expired;
  end

  assign bus.err_o = err_q;
`else
  wire unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout   = 1'b0;
  assign bus.err_o = 1'b0;
`endif

  // Next-state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)              state_nxt = ST_WAIT;
      ST_WAIT: if (sel_done || timeout) state_nxt = ST_RESP;
      ST_RESP:                          state_nxt = ST_IDLE;
      default:                          state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: stall covers the accepting IDLE cycle plus all of WAIT, which
  // gives the two-cycle minimum when done comes on the first WAIT cycle.
  always_comb begin
    bus.stall_o = 1'b0;
    bus.slv_req = 1'b0;
    bus.mst_req = 1'b0;
    if (accept) bus.stall_o = 1'b1;
    if (state == ST_WAIT) begin
      bus.stall_o = 1'b1;
      bus.slv_req = tgt_slv;
      bus.mst_req = !tgt_slv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      tgt_slv <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      // Attributes are captured only at accept, keeping ext_* stable through
      // WAIT. A read (we_i == 0) reaches the target as ext_we == 4'b0000.
      if (accept) begin
        tgt_slv <= bus.en_slave;
        addr_q  <= bus.daddr;
        wdata_q <= bus.dwdata;
        we_q    <= bus.we_i;
      end
      // rdata_o only changes when entering RESP and holds otherwise.
      if (state == ST_WAIT) begin
        if (sel_done)     rdata_q <= sel_rdata;
        else if (timeout) rdata_q <= ERR_RDATA;
      end
    end
  end

  assign bus.ext_addr  = addr_q;
  assign bus.ext_wdata = wdata_q;
  assign bus.ext_we    = we_q;
  assign bus.rdata_o   = rdata_q;

endmodule
